// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. It performs RV64I loads and stores over a
// req/ready data-memory port. It resolves branches from the execute compare bit
// and produces the registered write-back bundle. Upstream is stalled while an
// access is outstanding, and a stuck access is abandoned after WAIT_MAX cycles.
module mem_stage #(
   parameter int WAIT_MAX = 255,
   parameter int XLEN     = 64
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [XLEN-1:0] res_i,
   input  logic            wb_en_i,
   input  logic [4:0]      rd_i,
   input  logic            load_flag_i,
   input  logic            mem_en_i,
   input  logic [2:0]      mem_para_i,
   input  logic [XLEN-1:0] store_value_i,
   input  logic            branch_flag_i,
   input  logic [XLEN-1:0] branch_offset_i,
   input  logic [XLEN-1:0] PC_i,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            take_branch,
   output logic [XLEN-1:0] branch_target,
   output logic            misalign,
   output logic            bus_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Last counter value before the access is abandoned.
   localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_MAX - 1);

   // Store data replicated across every lane the access could occupy.
   function automatic logic [63:0] f_store_data(input logic [63:0] v, input logic [1:0] size);
      logic [63:0] d;
      case (size)
         2'b00:   d = {8{v[7:0]}};
         2'b01:   d = {4{v[15:0]}};
         2'b10:   d = {2{v[31:0]}};
         default: d = v;
      endcase
      return d;
   endfunction

   // Byte enables for a naturally aligned access at byte offset off.
   function automatic logic [7:0] f_store_strb(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] s;
      case (size)
         2'b00:   s = 8'h01 << off;
         2'b01:   s = 8'h03 << off;
         2'b10:   s = 8'h0F << off;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Move the addressed bytes down to bit 0, then sign- or zero-extend.
   function automatic logic [63:0] f_load_ext(input logic [63:0] rdata, input logic [2:0] off,
                                              input logic [2:0] para);
      logic [63:0] sh;
      logic [63:0] d;
      sh = rdata >> {off, 3'b000};
      case (para)
         3'b000:  d = {{56{sh[7]}}, sh[7:0]};
         3'b001:  d = {{48{sh[15]}}, sh[15:0]};
         3'b010:  d = {{32{sh[31]}}, sh[31:0]};
         3'b100:  d = {56'd0, sh[7:0]};
         3'b101:  d = {48'd0, sh[15:0]};
         3'b110:  d = {32'd0, sh[31:0]};
         default: d = sh;
      endcase
      return d;
   endfunction

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_req;
   logic              r_we;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [7:0]        r_wstrb;
   logic [2:0]        r_off;
   logic [2:0]        r_para;
   logic              r_load;
   logic              r_sv_wb_en;
   logic [4:0]        r_sv_rd;
   logic              r_wb_en;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_take_branch;
   logic [XLEN-1:0]   r_branch_target;
   logic              r_misalign;
   logic              r_bus_err;

   logic              w_op_valid;
   logic              w_misaligned;
   logic              w_issue;
   logic              w_timeout;
   logic [XLEN-1:0]   w_load_data;

   // Decode the incoming memory instruction: legality, alignment and issue.
   always_comb begin
      w_op_valid   = 1'b0;
      w_misaligned = 1'b0;
      if (load_flag_i) begin
         w_op_valid = (mem_para_i != 3'b111);
      end else begin
         w_op_valid = (mem_para_i[2] == 1'b0);
      end
      case (mem_para_i[1:0])
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = res_i[0];
         2'b10:   w_misaligned = |res_i[1:0];
         default: w_misaligned = |res_i[2:0];
      endcase
   end

   assign w_issue     = (r_state == ST_IDLE) && mem_en_i && w_op_valid && !w_misaligned;
   assign w_timeout   = (r_cnt == LP_CNT_LAST);
   assign w_load_data = f_load_ext(dmem_rdata, r_off, r_para);

   // Hold upstream while issuing and while waiting. Release on ready or on the abort cycle.
   assign stall = RST_N && (w_issue || ((r_state == ST_WAIT) && !dmem_ready && !w_timeout));

   // Stage FSM: request issue, completion/abort, pass-through and branch resolution.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state         <= ST_IDLE;
         r_cnt           <= 8'd0;
         r_req           <= 1'b0;
         r_we            <= 1'b0;
         r_addr          <= 64'd0;
         r_wdata         <= 64'd0;
         r_wstrb         <= 8'd0;
         r_off           <= 3'd0;
         r_para          <= 3'd0;
         r_load          <= 1'b0;
         r_sv_wb_en      <= 1'b0;
         r_sv_rd         <= 5'd0;
         r_wb_en         <= 1'b0;
         r_wb_rd         <= 5'd0;
         r_wb_data       <= 64'd0;
         r_take_branch   <= 1'b0;
         r_branch_target <= 64'd0;
         r_misalign      <= 1'b0;
         r_bus_err       <= 1'b0;
      end else begin
         r_take_branch <= 1'b0;
         r_misalign    <= 1'b0;
         r_bus_err     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= 8'd0;
               if (mem_en_i) begin
                  r_wb_en <= 1'b0;
                  if (!w_op_valid) begin
                     r_req <= 1'b0;
                  end else if (w_misaligned) begin
                     r_misalign <= 1'b1;
                  end else begin
                     r_req      <= 1'b1;
                     r_we       <= !load_flag_i;
                     r_addr     <= {res_i[63:3], 3'b000};
                     r_wdata    <= f_store_data(store_value_i, mem_para_i[1:0]);
                     r_wstrb    <= f_store_strb(mem_para_i[1:0], res_i[2:0]);
                     r_off      <= res_i[2:0];
                     r_para     <= mem_para_i;
                     r_load     <= load_flag_i;
                     r_sv_wb_en <= wb_en_i;
                     r_sv_rd    <= rd_i;
                     r_state    <= ST_WAIT;
                  end
               end else if (branch_flag_i) begin
                  r_wb_en         <= 1'b0;
                  r_take_branch   <= res_i[0];
                  r_branch_target <= PC_i + branch_offset_i;
               end else begin
                  r_wb_en   <= wb_en_i;
                  r_wb_rd   <= rd_i;
                  r_wb_data <= res_i;
               end
            end
            ST_WAIT: begin
               r_wb_en <= 1'b0;
               if (dmem_ready) begin
                  r_wb_en <= r_sv_wb_en & r_load;
                  r_wb_rd <= r_sv_rd;
                  if (r_load) begin
                     r_wb_data <= w_load_data;
                  end else begin
                     r_wb_data <= r_wb_data;
                  end
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_state <= ST_IDLE;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_req     <= 1'b0;
                  r_we      <= 1'b0;
                  r_cnt     <= 8'd0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_we    <= 1'b0;
               r_cnt   <= 8'd0;
               r_wb_en <= 1'b0;
            end
         endcase
      end
   end

   assign dmem_req      = r_req;
   assign dmem_we       = r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign dmem_wstrb    = r_wstrb;
   assign wb_en         = r_wb_en;
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;
   assign take_branch   = r_take_branch;
   assign branch_target = r_branch_target;
   assign misalign      = r_misalign;
   assign bus_err       = r_bus_err;

endmodule
